uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 97 +++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default bit period, counter width and receiver state encoding.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_D = 234;  // round(27 MHz / 115200 bit/s)
  localparam int UART_L = 8;    // 2**UART_L must exceed UART_D

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both flops reset to 1 so a reset never looks like a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a start edge, one-cycle valid/framing-error pulses.
// Stop-bit result is registered at start edge + 2 + D/2 + 9*D cycles; there is no downstream handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int D = UART_D,
  parameter int L = UART_L
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_ferr,
  output logic       o_busy
);

  localparam logic [L-1:0] HALF = L'(D / 2 - 1);
  localparam logic [L-1:0] LAST = L'(D - 1);

  uart_rx_state_t state;
  logic [L-1:0]   cnt;
  logic [2:0]     idx;
  logic [7:0]     shreg;
  logic           rx;

  uart_sync2 u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_rx),
    .q   (rx)
  );

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) state <= START;
        end
        START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx) begin
              o_data  <= shreg;
              o_valid <= 1'b1;
              state   <= IDLE;
            end else begin
              o_ferr <= 1'b1;
              state  <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Wait out a held-low line so it cannot be re-read as new frames.
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames and checks every output each cycle
// against a frame-level timing model, plus literal expectations per scenario.
module tb_uart_rx;

  localparam int D = 234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ferr;
  logic       o_busy;

  uart_rx #(.D(D), .L(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_rx    (rx),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ferr  (o_ferr),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t0;         // edge at which the falling line is first sampled
    int         pulse_at;   // sample index at which the pulse is visible
    bit         has_pulse;
    bit         ferr;
    logic [7:0] data;
    int         busy_end;   // last sample index with busy high
  } rec_t;

  rec_t recs[$];
  int   valid_edges[$];
  int   valid_datas[$];
  int   ferr_edges[$];
  int   edge_n    = 0;
  int   busy_cnt  = 0;
  int   tests     = 0;
  int   fails     = 0;
  logic [7:0] mdata = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int ve(input int i);
    return (i < valid_edges.size()) ? valid_edges[i] : -1;
  endfunction

  function automatic int vd(input int i);
    return (i < valid_datas.size()) ? valid_datas[i] : -1;
  endfunction

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      bit exp_v, exp_f, exp_b;
      @(posedge clk);
      #1;
      edge_n++;
      exp_v = 1'b0;
      exp_f = 1'b0;
      exp_b = 1'b0;
      foreach (recs[i]) begin
        if (recs[i].has_pulse && recs[i].pulse_at == edge_n) begin
          if (recs[i].ferr) exp_f = 1'b1;
          else begin
            exp_v = 1'b1;
            mdata = recs[i].data;
          end
        end
        if (edge_n >= recs[i].t0 + 2 && edge_n <= recs[i].busy_end) exp_b = 1'b1;
      end
      if (rst) mdata = 8'h00;
      check("valid", o_valid, exp_v);
      check("ferr",  o_ferr,  exp_f);
      check("busy",  o_busy,  exp_b);
      check("data",  o_data,  mdata);
      if (o_valid) begin
        valid_edges.push_back(edge_n);
        valid_datas.push_back(o_data);
      end
      if (o_ferr) ferr_edges.push_back(edge_n);
      if (o_busy) busy_cnt++;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first and the stop level at p cycles per bit.
  // abort_bit >= 0 asserts reset halfway through that data bit.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int p,
                            input int abort_bit, output int t0);
    rec_t r;
    t0          = edge_n + 1;
    r.t0        = t0;
    r.pulse_at  = t0 + 2 + D / 2 + 9 * D;
    r.has_pulse = 1'b1;
    r.ferr      = !stop;
    r.data      = b;
    r.busy_end  = stop ? r.pulse_at - 1 : 32'h3fff_ffff;
    recs.push_back(r);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == abort_bit) begin
        repeat (p / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        recs[recs.size() - 1].busy_end  = edge_n;
        recs[recs.size() - 1].has_pulse = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        return;
      end
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
  endtask

  task automatic glitch(input int n);
    rec_t r;
    r.t0        = edge_n + 1;
    r.pulse_at  = -1;
    r.has_pulse = 1'b0;
    r.ferr      = 1'b0;
    r.data      = 8'h00;
    r.busy_end  = r.t0 + 1 + D / 2;
    recs.push_back(r);
    rx = 1'b0;
    repeat (n) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int t0, t1, b0;
    repeat (3) @(negedge clk);
    check("rst_data",  o_data,  8'h00);
    check("rst_valid", o_valid, 0);
    check("rst_busy",  o_busy,  0);
    rst = 1'b0;
    idle(10);

    // Single frame latency and data.
    send_frame(8'h55, 1'b1, D, -1, t0);
    idle(20);
    check("s1_count",   valid_edges.size(), 1);
    check("s1_latency", ve(0) - t0, 2225);
    check("s1_data",    o_data, 8'h55);

    // Short glitch on an idle line.
    b0 = busy_cnt;
    glitch(50);
    idle(200);
    check("glitch_busy",  busy_cnt - b0, 117);
    check("glitch_count", valid_edges.size(), 1);

    // Stop bit low, line held low for 3 more bit times.
    send_frame(8'h3C, 1'b0, D, -1, t0);
    repeat (3 * D) @(negedge clk);
    rx = 1'b1;
    recs[recs.size() - 1].busy_end = edge_n + 2;
    idle(20);
    check("ferr_count",   ferr_edges.size(), 1);
    check("ferr_latency", (ferr_edges.size() > 0) ? ferr_edges[0] - t0 : -1, 2225);
    check("ferr_data",    o_data, 8'h55);
    check("ferr_busy",    o_busy, 0);
    check("ferr_nvalid",  valid_edges.size(), 1);

    // Back-to-back frames with no idle bit.
    send_frame(8'hA3, 1'b1, D, -1, t0);
    send_frame(8'h00, 1'b1, D, -1, t1);
    idle(20);
    check("b2b_gap",   ve(2) - ve(1), 2340);
    check("b2b_data0", vd(1), 8'hA3);
    check("b2b_data1", vd(2), 8'h00);

    // Reset during bit 4, then a clean frame.
    send_frame(8'h5A, 1'b1, D, 4, t0);
    check("abort_data",  o_data, 8'h00);
    check("abort_count", valid_edges.size(), 3);
    idle(20);
    send_frame(8'h81, 1'b1, D, -1, t0);
    idle(20);
    check("post_rst_data", vd(3), 8'h81);

    // Slow transmitter, D+3 cycles per bit.
    send_frame(8'hF0, 1'b1, D + 3, -1, t0);
    idle(20);
    check("slow_data",    vd(4), 8'hF0);
    check("slow_latency", ve(4) - t0, 2225);

    check("total_valid", valid_edges.size(), 5);
    check("total_ferr",  ferr_edges.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
